// File: rtl/bus_timer_pkg.sv
// bus_timer shared constants.
// Register offsets and CTRL/STAT bit positions.
package bus_timer_pkg;

  localparam int REG_CTRL  = 0;
  localparam int REG_STAT  = 1;
  localparam int REG_PRE   = 2;
  localparam int REG_LLO   = 3;
  localparam int REG_LHI   = 4;
  localparam int REG_CLO   = 5;
  localparam int REG_CHI   = 6;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IE     = 1;
  localparam int CTRL_RELOAD = 2;

  localparam int STAT_TF  = 0;
  localparam int STAT_RUN = 7;

  localparam logic [15:0] LATCH_RST = 16'hFFFF;

endpackage

// File: rtl/bus_timer_if.sv
// bus_timer CPU-side register bus.
// The CPU is the master; the timer is the slave.
interface bus_timer_if #(
  parameter int ADDR_W = 3
) ();

  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] rs;
  logic [7:0]        din;
  logic [7:0]        dout;
  logic              irq;

  modport master (
    output cs, we, rs, din,
    input  dout, irq
  );

  modport slave (
    input  cs, we, rs, din,
    output dout, irq
  );

endinterface

// File: rtl/bus_timer.sv
// bus_timer: 16-bit down-counter behind an 8-bit prescaler,
// with one-shot/auto-reload modes and an atomic 16-bit read.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  bus_timer_if.slave bus
);

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(REG_CTRL);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(REG_STAT);
  localparam logic [ADDR_W-1:0] A_PRE  = ADDR_W'(REG_PRE);
  localparam logic [ADDR_W-1:0] A_LLO  = ADDR_W'(REG_LLO);
  localparam logic [ADDR_W-1:0] A_LHI  = ADDR_W'(REG_LHI);
  localparam logic [ADDR_W-1:0] A_CLO  = ADDR_W'(REG_CLO);
  localparam logic [ADDR_W-1:0] A_CHI  = ADDR_W'(REG_CHI);

  logic        en;
  logic        ie;
  logic        reload;
  logic        tf;
  logic [7:0]  pre;
  logic [7:0]  pre_lim;
  logic [7:0]  psc;
  logic [15:0] latch;
  logic [15:0] cnt;
  logic [7:0]  snap;
  logic [7:0]  dout_q;

  logic        wr;
  logic        rd;
  logic        wr_ctrl;
  logic        wr_stat;
  logic        wr_pre;
  logic        wr_llo;
  logic        wr_lhi;
  logic        rd_clo;
  logic [7:0]  lim;
  logic        wrap;
  logic        tick;
  logic        tset;
  logic [7:0]  ctrl_v;
  logic [7:0]  stat_v;
  logic [7:0]  rdata;

  always_comb begin
    wr      = bus.cs & bus.we;
    rd      = bus.cs & ~bus.we;
    wr_ctrl = wr && (bus.rs == A_CTRL);
    wr_stat = wr && (bus.rs == A_STAT);
    wr_pre  = wr && (bus.rs == A_PRE);
    wr_llo  = wr && (bus.rs == A_LLO);
    wr_lhi  = wr && (bus.rs == A_LHI);
    rd_clo  = rd && (bus.rs == A_CLO);
  end

  // A period's length is sampled when it starts (prescaler at 0),
  // so a PRE write lands on the next wrap.
  always_comb begin
    lim  = (psc == 8'd0) ? pre : pre_lim;
    wrap = (psc == lim);
    tick = en && wrap && !wr_lhi;
    tset = tick && (cnt == 16'd0);
  end

  always_comb begin
    ctrl_v              = '0;
    ctrl_v[CTRL_EN]     = en;
    ctrl_v[CTRL_IE]     = ie;
    ctrl_v[CTRL_RELOAD] = reload;
    stat_v              = '0;
    stat_v[STAT_TF]     = tf;
    stat_v[STAT_RUN]    = en;
  end

  always_comb begin
    rdata = 8'h00;
    case (bus.rs)
      A_CTRL:  rdata = ctrl_v;
      A_STAT:  rdata = stat_v;
      A_PRE:   rdata = pre;
      A_LLO:   rdata = latch[7:0];
      A_LHI:   rdata = latch[15:8];
      A_CLO:   rdata = cnt[7:0];
      A_CHI:   rdata = snap;
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc     <= 8'd0;
      pre_lim <= 8'd0;
    end else if (wr_lhi) begin
      psc     <= 8'd0;
    end else if (en) begin
      if (psc == 8'd0) pre_lim <= pre;
      psc <= wrap ? 8'd0 : psc + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= LATCH_RST;
    end else if (wr_lhi) begin
      cnt <= {bus.din, latch[7:0]};
    end else if (tick) begin
      if (cnt != 16'd0) cnt <= cnt - 16'd1;
      else if (reload)  cnt <= latch;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en     <= 1'b0;
      ie     <= 1'b0;
      reload <= 1'b0;
    end else if (wr_ctrl) begin
      en     <= bus.din[CTRL_EN];
      ie     <= bus.din[CTRL_IE];
      reload <= bus.din[CTRL_RELOAD];
    end else if (tset && !reload) begin
      en     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tf <= 1'b0;
    end else if (tset) begin
      tf <= 1'b1;
    end else if (wr_stat && bus.din[STAT_TF]) begin
      tf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre   <= 8'h00;
      latch <= LATCH_RST;
    end else begin
      if (wr_pre) pre <= bus.din;
      if (wr_llo) latch[7:0] <= bus.din;
      if (wr_lhi) latch[15:8] <= bus.din;
    end
  end

  // High byte is frozen by the low-byte read for a tear-free 16-bit read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap   <= 8'h00;
      dout_q <= 8'h00;
    end else begin
      if (rd_clo) snap   <= cnt[15:8];
      if (rd)     dout_q <= rdata;
    end
  end

  assign bus.dout = dout_q;
  assign bus.irq  = tf & ie;

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, register-select width (8 registers).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cs  input  1  chip select from SoC page decode.
REQ-005 SHALL have port we  input  1  CPU write enable; write when cs=1, we=1.
REQ-006 SHALL have port rs  input  ADDR_W  register select (CPU_AB low bits).
REQ-007 SHALL have port din  input  8  CPU write data.
REQ-008 SHALL have port dout  output  8  registered read data.
REQ-009 SHALL have port irq  output  1  active-high interrupt request.

Function
REQ-010 SHALL implement the register map: 0 CTRL (b0 EN, b1 IE, b2 RELOAD, b7:3 read 0); 1 STAT (b0 TF, b7 RUN=EN, others 0); 2 PRE; 3 LATCH_LO; 4 LATCH_HI; 5 CNT_LO; 6 CNT_HI; 7 reads 0x00, writes ignored.
REQ-011 SHALL register reads: when cs=1 and we=0 at edge N, dout holds the selected value after edge N; otherwise dout holds its last value.
REQ-012 SHALL generate a tick every PRE+1 clocks while EN=1, using an 8-bit prescaler that counts 0..PRE and wraps to 0.
REQ-013 SHALL hold the prescaler and 16-bit counter frozen while EN=0.
REQ-014 SHALL, on a tick with counter≠0, decrement the counter by 1.
REQ-015 SHALL, on a tick with counter=0, set TF; if RELOAD=1, load counter from the 16-bit latch; if RELOAD=0, clear EN (one-shot), leaving counter at 0.
REQ-016 SHALL, on a write to LATCH_HI, load the counter with {din, LATCH_LO} and zero the prescaler in the same edge; this write takes precedence over a coincident tick.
REQ-017 SHALL, on a write to LATCH_LO, update only the latch low byte.
REQ-018 SHALL clear TF when STAT is written with din[0]=1; a coincident TF set wins (TF stays 1).
REQ-019 SHALL, on a read of CNT_LO, return counter[7:0] and capture counter[15:8] into a snapshot register in the same edge; a read of CNT_HI returns the snapshot.
REQ-020 SHALL drive irq = TF AND IE from registered state (no combinational path from bus inputs).
REQ-021 SHALL ignore writes to CNT_LO/CNT_HI; writing PRE takes effect at the next prescaler wrap.

Reset
REQ-022 SHALL, on reset low, asynchronously set CTRL=0x00, TF=0, PRE=0x00, latch=0xFFFF, counter=0xFFFF, snapshot=0x00, prescaler=0, dout=0x00, irq=0.
REQ-023 SHALL abandon any count in progress when reset asserts mid-operation; no tick or TF set in the first edge after release.

Structure
REQ-024 SHALL place register-offset constants (CTRL..CNT_HI) and CTRL/STAT bit positions in shared package bus_timer_pkg.
REQ-025 SHALL be one module with no sub-modules; the prescaler is inline logic.

Verification
REQ-026 SHALL check reset: after release, reads of CTRL, STAT, CNT_LO, CNT_HI -> 0x00, 0x00, 0xFF, 0xFF; irq=0.
REQ-027 SHALL check one-shot: PRE=0x03, LATCH=0x0002, CTRL=0x03 -> TF and irq rise 12 clocks after enable, EN clears, CTRL reads 0x02.
REQ-028 SHALL check auto-reload: PRE=0x00, LATCH=0x0004, CTRL=0x05 -> TF sets every 5 clocks, counter sequence 4,3,2,1,0,4.
REQ-029 SHALL check atomic read: counter at 0x0100, PRE=0 -> CNT_LO read returns 0x00 and subsequent CNT_HI read returns 0x01 even though counter has moved to 0x00FF.
REQ-030 SHALL check collisions: STAT write 0x01 on the TF-setting edge -> TF stays 1; LATCH_HI write on a tick edge -> counter equals new latch, prescaler 0.
REQ-031 SHALL check reset mid-count: assert reset with counter 0x0003, EN=1 -> all registers at reset values, no irq after release.
